// File: rtl/core_arb2.sv
// core_arb2: 2:1 arbiter sharing one req/gnt/rvalid core memory port, one transaction in flight.
// Define CORE_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module core_arb2 #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [1:0]              m_req,
    input  logic [1:0]              m_we,
    input  logic [2*(DATA_W/8)-1:0] m_be,
    input  logic [2*ADDR_W-1:0]     m_addr,
    input  logic [2*DATA_W-1:0]     m_wdata,
    output logic [1:0]              m_gnt,
    output logic [1:0]              m_rvalid,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    m_err,
    output logic                    s_req,
    output logic                    s_we,
    output logic [DATA_W/8-1:0]     s_be,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic                    s_gnt,
    input  logic                    s_rvalid,
    input  logic [DATA_W-1:0]       s_rdata,
    input  logic                    s_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic             r_owner;
    logic [CNT_W-1:0] r_cnt;

    logic w_win;
    logic w_fire;
    logic w_timeout;

`ifdef CORE_ARB_RR_EN
    logic r_rr_ptr;

    // On a tie the pointer decides; a lone requester always wins.
    assign w_win = (&m_req) ? r_rr_ptr : (m_req[1] & ~m_req[0]);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rr_ptr <= 1'b0;
        end else if (w_fire) begin
            r_rr_ptr <= ~w_win;
        end
    end
`else
    assign w_win = m_req[1] & ~m_req[0];
`endif

    assign w_fire    = s_req & s_gnt;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    assign m_rdata   = s_rdata;

    // Request fields follow the winner combinationally; only s_req is qualified.
    assign s_we    = w_win ? m_we[1] : m_we[0];
    assign s_be    = w_win ? m_be[2*BE_W-1:BE_W] : m_be[BE_W-1:0];
    assign s_addr  = w_win ? m_addr[2*ADDR_W-1:ADDR_W] : m_addr[ADDR_W-1:0];
    assign s_wdata = w_win ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        s_req    = 1'b0;
        m_gnt    = 2'b00;
        m_rvalid = 2'b00;
        m_err    = 1'b0;
        if (!areset) begin
            case (r_state)
                ST_IDLE: begin
                    s_req        = |m_req;
                    m_gnt[w_win] = s_gnt & (|m_req);
                end
                ST_WAIT: begin
                    if (s_rvalid) begin
                        m_rvalid[r_owner] = 1'b1;
                        m_err             = s_err;
                    end else if (w_timeout) begin
                        m_rvalid[r_owner] = 1'b1;
                        m_err             = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (areset) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        r_owner <= w_win;
                        r_cnt   <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (s_rvalid) begin
                        r_state <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // The lost response eventually arrives and is swallowed here.
                    if (s_rvalid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_arb2.sv
// Scoreboard bench for core_arb2 (TIMEOUT=4): stimulus pushes expected grants and responses,
// a negedge monitor pops and compares whenever the DUT presents m_gnt or m_rvalid.
module tb_core_arb2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            aclk = 1'b0;
    logic            areset;
    logic [1:0]      m_req, m_we;
    logic [2*BW-1:0] m_be;
    logic [2*AW-1:0] m_addr;
    logic [2*DW-1:0] m_wdata;
    logic [1:0]      m_gnt, m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic            m_err;
    logic            s_req, s_we;
    logic [BW-1:0]   s_be;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic            s_gnt, s_rvalid, s_err;
    logic [DW-1:0]   s_rdata;

    always #5 aclk = ~aclk;

    core_arb2 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .aclk(aclk), .areset(areset),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    int   total = 0;
    int   bad   = 0;
    int   gnt_q[$];
    rsp_t rsp_q[$];
    int   mon_p;
    rsp_t mon_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge aclk) begin
        if (!areset) begin
            if (m_gnt != 2'b00) begin
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", 64'(m_gnt), 64'd0);
                end else begin
                    mon_p = gnt_q.pop_front();
                    check("gnt_port", 64'(m_gnt), 64'(1) << mon_p);
                end
            end
            if (m_rvalid != 2'b00) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rvalid", 64'(m_rvalid), 64'd0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check("rsp_owner", 64'(m_rvalid), 64'(1) << mon_r.port);
                    check("rsp_data", 64'(m_rdata), 64'(mon_r.data));
                    check("rsp_err", 64'(m_err), 64'(mon_r.err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_master(input int p, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            m_we[0] = we; m_be[3:0] = be; m_addr[31:0] = addr; m_wdata[31:0] = wdata;
        end else begin
            m_we[1] = we; m_be[7:4] = be; m_addr[63:32] = addr; m_wdata[63:32] = wdata;
        end
    endtask

    task automatic grant(input int exp_p);
        s_gnt = 1'b1;
        gnt_q.push_back(exp_p);
        tick();
        s_gnt = 1'b0;
        check("gnt_seen", 64'(gnt_q.size()), 64'd0);
    endtask

    task automatic respond(input int exp_p, input logic [31:0] data, input logic err, input int lat);
        s_rvalid = 1'b0;
        repeat (lat - 1) tick();
        s_rvalid = 1'b1;
        s_rdata  = data;
        s_err    = err;
        rsp_q.push_back(rsp_t'{port: exp_p, data: data, err: err});
        tick();
        s_rvalid = 1'b0;
        s_err    = 1'b0;
        check("rsp_seen", 64'(rsp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    initial begin
        m_req = 2'b00; m_we = 2'b00; m_be = '0; m_addr = '0; m_wdata = '0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_err = 1'b0;

        // Reset: outputs held low even with every input asserted.
        areset = 1'b1;
        m_req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b1; s_err = 1'b1;
        @(negedge aclk);
        check("rst_s_req", 64'(s_req), 64'd0);
        check("rst_m_gnt", 64'(m_gnt), 64'd0);
        check("rst_m_rvalid", 64'(m_rvalid), 64'd0);
        check("rst_m_err", 64'(m_err), 64'd0);
        tick();
        areset = 1'b0;
        m_req = 2'b00; s_gnt = 1'b0; s_err = 1'b0;

        // Spurious s_rvalid in IDLE is ignored.
        s_rvalid = 1'b1;
        @(negedge aclk);
        check("spurious_rvalid", 64'(m_rvalid), 64'd0);
        tick();
        s_rvalid = 1'b0;

        // 1: single m0 read at 0x100.
        set_master(0, 1'b0, 4'hF, 32'h100, 32'h0);
        m_req = 2'b01;
        s_gnt = 1'b1;
        gnt_q.push_back(0);
        @(negedge aclk);
        check("t1_s_req", 64'(s_req), 64'd1);
        check("t1_s_addr", 64'(s_addr), 64'h100);
        tick();
        s_gnt = 1'b0;
        m_req = 2'b00;
        respond(0, 32'hDEADBEEF, 1'b0, 1);

        // 2: both masters request continuously for 4 transactions.
        do_reset();
        set_master(0, 1'b0, 4'hF, 32'h1000, 32'h0);
        set_master(1, 1'b0, 4'hF, 32'h2000, 32'h0);
        m_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef CORE_ARB_RR_EN
            grant(i % 2);
            respond(i % 2, 32'hA000_0000 + 32'(i), 1'b0, 1);
`else
            grant(0);
            respond(0, 32'hA000_0000 + 32'(i), 1'b0, 1);
`endif
        end
        m_req = 2'b00;

        // 3: m1 write held 3 cycles before s_gnt.
        set_master(1, 1'b1, 4'b0011, 32'h200, 32'h12345678);
        m_req = 2'b10;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                s_gnt = 1'b1;
                gnt_q.push_back(1);
            end
            @(negedge aclk);
            check("t3_s_req", 64'(s_req), 64'd1);
            check("t3_s_we", 64'(s_we), 64'd1);
            check("t3_s_addr", 64'(s_addr), 64'h200);
            check("t3_s_wdata", 64'(s_wdata), 64'h12345678);
            check("t3_s_be", 64'(s_be), 64'h3);
            check("t3_m_gnt", 64'(m_gnt), (c == 3) ? 64'h2 : 64'h0);
            tick();
        end
        s_gnt = 1'b0;
        m_req = 2'b00;
        respond(1, 32'h0000_0001, 1'b0, 2);

        // 4: error response, then a clean one.
        set_master(0, 1'b0, 4'hF, 32'h300, 32'h0);
        m_req = 2'b01;
        grant(0);
        m_req = 2'b00;
        respond(0, 32'hBAD0BAD0, 1'b1, 1);
        m_req = 2'b01;
        grant(0);
        m_req = 2'b00;
        respond(0, 32'h600D600D, 1'b0, 3);

        // 5: timeout on cycle 4, late response on cycle 9 swallowed, regrant on cycle 10.
        m_req = 2'b01;
        s_rdata = '0;
        grant(0);
        s_gnt = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge aclk);
            check("t5_wait_rvalid", 64'(m_rvalid), 64'd0);
            tick();
        end
        rsp_q.push_back(rsp_t'{port: 0, data: 32'h0, err: 1'b1});
        tick();
        check("t5_timeout_seen", 64'(rsp_q.size()), 64'd0);
        for (int c = 5; c <= 8; c++) begin
            @(negedge aclk);
            check("t5_drain_s_req", 64'(s_req), 64'd0);
            check("t5_drain_gnt", 64'(m_gnt), 64'd0);
            tick();
        end
        s_rvalid = 1'b1;
        s_rdata  = 32'hFFFF_FFFF;
        @(negedge aclk);
        check("t5_late_rvalid", 64'(m_rvalid), 64'd0);
        tick();
        s_rvalid = 1'b0;
        gnt_q.push_back(0);
        tick();
        check("t5_regrant", 64'(gnt_q.size()), 64'd0);
        s_gnt = 1'b0;
        m_req = 2'b00;
        respond(0, 32'h55AA55AA, 1'b0, 1);

        // 6: reset pulsed while waiting for a response.
        m_req = 2'b01;
        grant(0);
        s_gnt = 1'b1;
        #2;
        areset   = 1'b1;
        s_rvalid = 1'b1;
        @(negedge aclk);
        check("t6_rst_gnt", 64'(m_gnt), 64'd0);
        check("t6_rst_rvalid", 64'(m_rvalid), 64'd0);
        check("t6_rst_s_req", 64'(s_req), 64'd0);
        tick();
        tick();
        areset   = 1'b0;
        s_rvalid = 1'b0;
        s_gnt    = 1'b0;
        grant(0);
        m_req = 2'b00;
        respond(0, 32'h0BADCAFE, 1'b0, 2);

        tick();
        check("final_gnt_q", 64'(gnt_q.size()), 64'd0);
        check("final_rsp_q", 64'(rsp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
